// File: rtl/segmented_dual_port_ram_pkg.sv
// segmented_dual_port_ram_pkg: shared limits and sizing helpers for the segmented dual-port RAM.
package segmented_dual_port_ram_pkg;
   localparam int MAX_READ_LATENCY = 4;
   function automatic int addr_bits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction
endpackage

// File: rtl/segmented_dual_port_ram_pipeline.sv
// segmented_dual_port_ram_pipeline: reset-cleared valid shift chain with valid-enabled data registers.
module segmented_dual_port_ram_pipeline #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);
   logic [STAGES-1:0]            valid_q, valid_d;
   logic [STAGES-1:0][WIDTH-1:0] data_q, data_d;
   always_comb begin
      valid_d[0] = valid_i;
      data_d[0]  = data_i;
      for (int k = 1; k < STAGES; k++) begin
         valid_d[k] = valid_q[k-1];
         data_d[k]  = data_q[k-1];
      end
   end
   // Data only moves with a valid token, so the output holds between results.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         for (int k = 0; k < STAGES; k++)
            if (valid_d[k]) data_q[k] <= data_d[k];
      end
   end
   assign valid_o = valid_q[STAGES-1];
   assign data_o  = data_q[STAGES-1];
endmodule

// File: rtl/segmented_dual_port_ram.sv
// segmented_dual_port_ram: 1W1R RAM with segment write masks, 1-4 cycle read pipeline and range guard.
module segmented_dual_port_ram
   import segmented_dual_port_ram_pkg::*;
#(
   parameter  int WIDTH         = 32,
   parameter  int DEPTH         = 16,
   parameter  int SEGMENT_WIDTH = 8,
   parameter  int READ_LATENCY  = 1,
   parameter  int WRITE_THROUGH = 0,
   parameter  int ADDRESS_WIDTH = addr_bits(DEPTH),
   localparam int SEGMENTS      = WIDTH / SEGMENT_WIDTH
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     write_enable,
   input  logic [ADDRESS_WIDTH-1:0] write_address,
   input  logic [SEGMENTS-1:0]      write_segment_enable,
   input  logic [WIDTH-1:0]         write_data,
   input  logic                     read_enable,
   input  logic [ADDRESS_WIDTH-1:0] read_address,
   output logic                     read_valid,
   output logic [WIDTH-1:0]         read_data
);
   if (WIDTH % SEGMENT_WIDTH != 0 || READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_params
      $error("segmented_dual_port_ram: WIDTH must be a multiple of SEGMENT_WIDTH and READ_LATENCY in 1..4");
   end
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             wr_in_range, rd_in_range, forward;
   logic [WIDTH-1:0] rd_word, merged, stage_d;
   assign wr_in_range = 32'(write_address) < DEPTH;
   assign rd_in_range = 32'(read_address) < DEPTH;
   assign rd_word     = rd_in_range ? mem_q[read_address] : '0;
   assign forward     = (WRITE_THROUGH != 0) && write_enable && wr_in_range && (read_address == write_address);
   always_comb begin
      merged = rd_word;
      for (int i = 0; i < SEGMENTS; i++)
         if (write_segment_enable[i]) merged[i*SEGMENT_WIDTH +: SEGMENT_WIDTH] = write_data[i*SEGMENT_WIDTH +: SEGMENT_WIDTH];
   end
   assign stage_d = forward ? merged : rd_word;
   // The array itself is never reset; writes are simply held off while reset is high.
   always_ff @(posedge clock) begin
      if (!reset && write_enable && wr_in_range)
         for (int i = 0; i < SEGMENTS; i++)
            if (write_segment_enable[i])
               mem_q[write_address][i*SEGMENT_WIDTH +: SEGMENT_WIDTH] <= write_data[i*SEGMENT_WIDTH +: SEGMENT_WIDTH];
   end
   // Stage 1 is the array sample; the remaining stages are pure delay.
   segmented_dual_port_ram_pipeline #(
      .WIDTH  (WIDTH),
      .STAGES (READ_LATENCY)
   ) u_pipe (
      .clock   (clock),
      .reset   (reset),
      .valid_i (read_enable),
      .data_i  (stage_d),
      .valid_o (read_valid),
      .data_o  (read_data)
   );
endmodule

// File: tb/tb_segmented_dual_port_ram.sv
// tb_segmented_dual_port_ram: scoreboard bench driving a write-old (RL=3) and a write-through (RL=4) RAM in parallel.
module tb_segmented_dual_port_ram;
   localparam int RL_A = 3;
   localparam int RL_B = 4;
   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        write_enable = 1'b0;
   logic [3:0]  write_address = '0;
   logic [3:0]  write_segment_enable = '0;
   logic [31:0] write_data = '0;
   logic        read_enable = 1'b0;
   logic [3:0]  read_address = '0;
   logic        valid_a, valid_b;
   logic [31:0] data_a, data_b;
   exp_t        q_a[$], q_b[$];
   int          cyc = 0;
   int          tests = 0;
   int          fails = 0;
   segmented_dual_port_ram #(.WIDTH(32), .DEPTH(12), .SEGMENT_WIDTH(8), .READ_LATENCY(RL_A), .WRITE_THROUGH(0)) dut_a (
      .clock(clock), .reset(reset), .write_enable(write_enable), .write_address(write_address),
      .write_segment_enable(write_segment_enable), .write_data(write_data), .read_enable(read_enable),
      .read_address(read_address), .read_valid(valid_a), .read_data(data_a));
   segmented_dual_port_ram #(.WIDTH(32), .DEPTH(12), .SEGMENT_WIDTH(8), .READ_LATENCY(RL_B), .WRITE_THROUGH(1)) dut_b (
      .clock(clock), .reset(reset), .write_enable(write_enable), .write_address(write_address),
      .write_segment_enable(write_segment_enable), .write_data(write_data), .read_enable(read_enable),
      .read_address(read_address), .read_valid(valid_b), .read_data(data_b));
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   always @(negedge clock) begin
      exp_t e;
      if (valid_a) begin
         if (q_a.size() == 0) check("a_unexpected_valid", 32'd1, 32'd0);
         else begin
            e = q_a.pop_front();
            check("a_data", data_a, e.data);
            check("a_latency", 32'(cyc), 32'(e.due));
         end
      end
      if (valid_b) begin
         if (q_b.size() == 0) check("b_unexpected_valid", 32'd1, 32'd0);
         else begin
            e = q_b.pop_front();
            check("b_data", data_b, e.data);
            check("b_latency", 32'(cyc), 32'(e.due));
         end
      end
   end
   task automatic op(input logic we, input logic [3:0] wa, input logic [3:0] wm, input logic [31:0] wd,
                     input logic re, input logic [3:0] ra, input logic [31:0] ea, input logic [31:0] eb);
      @(negedge clock);
      write_enable = we;
      write_address = wa;
      write_segment_enable = wm;
      write_data = wd;
      read_enable = re;
      read_address = ra;
      if (re) begin
         q_a.push_back('{data: ea, due: cyc + RL_A});
         q_b.push_back('{data: eb, due: cyc + RL_B});
      end
   endtask
   task automatic wr(input logic [3:0] wa, input logic [3:0] wm, input logic [31:0] wd);
      op(1'b1, wa, wm, wd, 1'b0, 4'd0, 32'd0, 32'd0);
   endtask
   task automatic rd(input logic [3:0] ra, input logic [31:0] e);
      op(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, ra, e, e);
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) op(1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
   endtask
   initial begin
      repeat (2) @(negedge clock);
      check("a_reset_valid", 32'(valid_a), 32'd0);
      check("a_reset_data", data_a, 32'd0);
      check("b_reset_valid", 32'(valid_b), 32'd0);
      check("b_reset_data", data_b, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 12; i++) wr(4'(i), 4'b1111, 32'h1000 + i);
      for (int i = 0; i < 12; i++) rd(4'(i), 32'h1000 + i);
      wr(4'd3, 4'b1111, 32'hAABBCCDD);
      wr(4'd3, 4'b0101, 32'h11223344);
      rd(4'd3, 32'hAA22CC44);
      wr(4'd5, 4'b1111, 32'h0);
      op(1'b1, 4'd5, 4'b0011, 32'hFFFFFFFF, 1'b1, 4'd5, 32'h00000000, 32'h0000FFFF);
      rd(4'd5, 32'h0000FFFF);
      wr(4'd3, 4'b0000, 32'hDEADBEEF);
      rd(4'd3, 32'hAA22CC44);
      wr(4'd7, 4'b1111, 32'h12345678);
      rd(4'd7, 32'h12345678);
      wr(4'd7, 4'b1111, 32'h0);
      rd(4'd7, 32'h0);
      wr(4'd13, 4'b1111, 32'hCAFEF00D);
      wr(4'd12, 4'b1111, 32'hCAFEF00D);
      rd(4'd13, 32'h0);
      rd(4'd12, 32'h0);
      rd(4'd11, 32'h100B);
      rd(4'd0, 32'h1000);
      op(1'b1, 4'd2, 4'b1111, 32'h55, 1'b1, 4'd1, 32'h1001, 32'h1001);
      rd(4'd2, 32'h55);
      idle(6);
      check("a_hold_valid", 32'(valid_a), 32'd0);
      check("a_hold_data", data_a, 32'h55);
      check("b_hold_valid", 32'(valid_b), 32'd0);
      check("b_hold_data", data_b, 32'h55);
      rd(4'd9, 32'h1009);
      rd(4'd10, 32'h100A);
      @(negedge clock);
      reset = 1'b1;
      read_enable = 1'b0;
      write_enable = 1'b0;
      #1;
      check("a_midreset_valid", 32'(valid_a), 32'd0);
      check("a_midreset_data", data_a, 32'd0);
      check("b_midreset_valid", 32'(valid_b), 32'd0);
      check("b_midreset_data", data_b, 32'd0);
      q_a.delete();
      q_b.delete();
      @(negedge clock);
      reset = 1'b0;
      write_enable = 1'b1;
      write_address = 4'd4;
      write_segment_enable = 4'b1111;
      write_data = 32'h44444444;
      idle(6);
      rd(4'd9, 32'h1009);
      rd(4'd3, 32'hAA22CC44);
      rd(4'd4, 32'h44444444);
      rd(4'd8, 32'h1008);
      idle(1);
      for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clock);
      check("a_drain", 32'(q_a.size()), 32'd0);
      check("b_drain", 32'(q_b.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
